// File: rtl/voq_request_manager_if.sv
// Ingress/scheduler bus of the VOQ request manager: arrivals and schedules in,
// request matrix and per-input dequeue/drop/underflow status out.
interface voq_request_manager_if #(
    parameter int number_ports = 4
);
    localparam int dest_width = $clog2(number_ports);

    logic [number_ports-1:0]                arrival_valid;
    logic [dest_width*number_ports-1:0]     arrival_dest;
    logic                                   schedule_valid;
    logic [dest_width*number_ports-1:0]     destinations;
    logic [number_ports*number_ports-1:0]   request;
    logic [number_ports-1:0]                dequeue_valid;
    logic [dest_width*number_ports-1:0]     dequeue_dest;
    logic [number_ports-1:0]                drop;
    logic [number_ports-1:0]                underflow;

    modport master (
        output arrival_valid, arrival_dest, schedule_valid, destinations,
        input  request, dequeue_valid, dequeue_dest, drop, underflow
    );

    modport slave (
        input  arrival_valid, arrival_dest, schedule_valid, destinations,
        output request, dequeue_valid, dequeue_dest, drop, underflow
    );
endinterface

// File: rtl/voq_request_manager.sv
// Per-(input, output) VOQ packet counters feeding the crossbar scheduler's
// request matrix and turning each schedule into one dequeue per input.
module voq_request_manager #(
    parameter int number_ports = 4,
    parameter int count_width  = 3
) (
    input logic                  clk,
    input logic                  reset,
    voq_request_manager_if.slave bus
);
    localparam int dest_width = $clog2(number_ports);
    localparam logic [count_width-1:0] count_max_c = {count_width{1'b1}};
    localparam logic [count_width-1:0] count_one_c = count_width'(1);

    logic [count_width-1:0]               count_r      [number_ports][number_ports];
    logic [count_width-1:0]               count_next_s [number_ports][number_ports];
    logic [number_ports-1:0]              dequeue_valid_s;
    logic [number_ports-1:0]              drop_s;
    logic [number_ports-1:0]              underflow_s;
    logic [dest_width*number_ports-1:0]   dequeue_dest_s;
    logic [number_ports*number_ports-1:0] request_s;
    logic [number_ports-1:0]              dequeue_valid_r;
    logic [number_ports-1:0]              drop_r;
    logic [number_ports-1:0]              underflow_r;
    logic [dest_width*number_ports-1:0]   dequeue_dest_r;

    // Next-state counters and per-input dequeue/drop/underflow decisions.
    always_comb begin
        logic [dest_width-1:0] a_dest_s;
        logic [dest_width-1:0] s_dest_s;
        logic                  hit_s;
        count_next_s    = count_r;
        dequeue_valid_s = '0;
        drop_s          = '0;
        underflow_s     = '0;
        dequeue_dest_s  = '0;
        a_dest_s        = '0;
        s_dest_s        = '0;
        hit_s           = 1'b0;
        for (int i = 0; i < number_ports; i++) begin
            a_dest_s = bus.arrival_dest[i*dest_width +: dest_width];
            s_dest_s = bus.destinations[i*dest_width +: dest_width];
            // An arrival and a dequeue on the same VOQ cancel: the packet cuts through.
            hit_s = bus.arrival_valid[i] && bus.schedule_valid && (a_dest_s == s_dest_s);
            if (bus.arrival_valid[i] && !hit_s) begin
                if (count_r[i][a_dest_s] == count_max_c) begin
                    drop_s[i] = 1'b1;
                end else begin
                    count_next_s[i][a_dest_s] = count_r[i][a_dest_s] + count_one_c;
                end
            end else begin
                drop_s[i] = 1'b0;
            end
            if (bus.schedule_valid) begin
                if (hit_s) begin
                    dequeue_valid_s[i] = 1'b1;
                    dequeue_dest_s[i*dest_width +: dest_width] = s_dest_s;
                end else if (count_r[i][s_dest_s] != '0) begin
                    count_next_s[i][s_dest_s] = count_r[i][s_dest_s] - count_one_c;
                    dequeue_valid_s[i] = 1'b1;
                    dequeue_dest_s[i*dest_width +: dest_width] = s_dest_s;
                end else begin
                    underflow_s[i] = 1'b1;
                end
            end else begin
                underflow_s[i] = 1'b0;
            end
        end
    end

    // Request matrix straight from the registered counts.
    always_comb begin
        request_s = '0;
        for (int i = 0; i < number_ports; i++) begin
            for (int j = 0; j < number_ports; j++) begin
                request_s[i*number_ports + j] = (count_r[i][j] != '0);
            end
        end
    end

    // Counter storage and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < number_ports; i++) begin
                for (int j = 0; j < number_ports; j++) begin
                    count_r[i][j] <= '0;
                end
            end
            dequeue_valid_r <= '0;
            dequeue_dest_r  <= '0;
            drop_r          <= '0;
            underflow_r     <= '0;
        end else begin
            count_r         <= count_next_s;
            dequeue_valid_r <= dequeue_valid_s;
            dequeue_dest_r  <= dequeue_dest_s;
            drop_r          <= drop_s;
            underflow_r     <= underflow_s;
        end
    end

    assign bus.request       = request_s;
    assign bus.dequeue_valid = dequeue_valid_r;
    assign bus.dequeue_dest  = dequeue_dest_r;
    assign bus.drop          = drop_r;
    assign bus.underflow     = underflow_r;
endmodule

// File: tb/tb_voq_request_manager.sv
// Scoreboard bench for voq_request_manager (n = 4, count_width = 3): directed
// vectors push expected status events; a negedge monitor pops and compares them.
module tb_voq_request_manager;
    logic clk;
    logic reset;

    voq_request_manager_if #(.number_ports(4)) bus ();

    voq_request_manager #(.number_ports(4), .count_width(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [3:0] dv;
        logic [7:0] dd;
        logic [3:0] drop;
        logic [3:0] uf;
    } ev_t;

    ev_t exp_q[$];
    int  checks;
    int  failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus; optionally queue the status event it must cause.
    task automatic step(input logic [3:0] av, input logic [7:0] ad, input logic sv,
                        input logic [7:0] ds, input logic ev, input logic [3:0] e_dv,
                        input logic [7:0] e_dd, input logic [3:0] e_drop, input logic [3:0] e_uf);
        ev_t e;
        bus.arrival_valid  = av;
        bus.arrival_dest   = ad;
        bus.schedule_valid = sv;
        bus.destinations   = ds;
        if (ev) begin
            e.dv = e_dv; e.dd = e_dd; e.drop = e_drop; e.uf = e_uf;
            exp_q.push_back(e);
        end
        @(negedge clk);
        bus.arrival_valid  = 4'b0000;
        bus.schedule_valid = 1'b0;
    endtask

    // Monitor: every non-idle status cycle must match the oldest queued event.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if ((bus.dequeue_valid | bus.drop | bus.underflow) != 4'b0000) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event dv=%b dd=%h drop=%b uf=%b required=none",
                             bus.dequeue_valid, bus.dequeue_dest, bus.drop, bus.underflow);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    chk("dequeue_valid", {12'h000, bus.dequeue_valid}, {12'h000, e.dv});
                    chk("dequeue_dest",  {8'h00, bus.dequeue_dest},    {8'h00, e.dd});
                    chk("drop",          {12'h000, bus.drop},          {12'h000, e.drop});
                    chk("underflow",     {12'h000, bus.underflow},     {12'h000, e.uf});
                end
            end else if (bus.dequeue_dest != 8'h00) begin
                checks++;
                failures++;
                $display("FAIL idle_dequeue_dest actual=%h expected=00", bus.dequeue_dest);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        bus.arrival_valid  = 4'b0000;
        bus.arrival_dest   = 8'h00;
        bus.schedule_valid = 1'b0;
        bus.destinations   = 8'h00;

        // Reset held with random inputs.
        for (int k = 0; k < 3; k++) begin
            bus.arrival_valid  = 4'($urandom);
            bus.arrival_dest   = 8'($urandom);
            bus.schedule_valid = 1'($urandom);
            bus.destinations   = 8'($urandom);
            @(negedge clk);
        end
        bus.arrival_valid  = 4'b0000;
        bus.schedule_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("reset_request",   bus.request, 16'h0000);
        chk("reset_dq_valid",  {12'h000, bus.dequeue_valid}, 16'h0000);
        chk("reset_drop",      {12'h000, bus.drop}, 16'h0000);
        chk("reset_underflow", {12'h000, bus.underflow}, 16'h0000);

        // Arrival at input 0 for output 2.
        step(4'b0001, 8'h02, 1'b0, 8'h00, 1'b0, 4'h0, 8'h00, 4'h0, 4'h0);
        chk("arrival_request", bus.request, 16'h0004);

        // Two packets into VOQ[1][3], then two schedules draining it.
        step(4'b0010, 8'h0C, 1'b0, 8'h00, 1'b0, 4'h0, 8'h00, 4'h0, 4'h0);
        step(4'b0010, 8'h0C, 1'b0, 8'h00, 1'b0, 4'h0, 8'h00, 4'h0, 4'h0);
        chk("load_1_3_request", bus.request, 16'h0084);
        step(4'b0000, 8'h00, 1'b1, 8'h0C, 1'b1, 4'b0010, 8'h0C, 4'h0, 4'b1101);
        chk("deq1_request", bus.request, 16'h0084);
        step(4'b0000, 8'h00, 1'b1, 8'h0C, 1'b1, 4'b0010, 8'h0C, 4'h0, 4'b1101);
        chk("deq2_request", bus.request, 16'h0004);

        // Saturation of VOQ[0][1]: eighth arrival drops.
        for (int k = 0; k < 7; k++)
            step(4'b0001, 8'h01, 1'b0, 8'h00, 1'b0, 4'h0, 8'h00, 4'h0, 4'h0);
        step(4'b0001, 8'h01, 1'b0, 8'h00, 1'b1, 4'h0, 8'h00, 4'b0001, 4'h0);
        chk("sat_request", bus.request, 16'h0006);
        for (int k = 0; k < 7; k++)
            step(4'b0000, 8'h00, 1'b1, 8'h01, 1'b1, 4'b0001, 8'h01, 4'h0, 4'b1110);
        chk("sat_drained_request", bus.request, 16'h0004);
        step(4'b0000, 8'h00, 1'b1, 8'h01, 1'b1, 4'b0000, 8'h00, 4'h0, 4'b1111);

        // Cut-through on empty VOQ[2][0], then drain VOQ[0][2].
        step(4'b0100, 8'h00, 1'b1, 8'h00, 1'b1, 4'b0100, 8'h00, 4'h0, 4'b1011);
        chk("cut_through_request", bus.request, 16'h0004);
        step(4'b0000, 8'h00, 1'b1, 8'h02, 1'b1, 4'b0001, 8'h02, 4'h0, 4'b1110);
        chk("empty_request", bus.request, 16'h0000);

        // Full VOQ[3][1] with same-edge arrival+dequeue, then split arrival/dequeue.
        for (int k = 0; k < 7; k++)
            step(4'b1000, 8'h40, 1'b0, 8'h00, 1'b0, 4'h0, 8'h00, 4'h0, 4'h0);
        chk("full_3_1_request", bus.request, 16'h2000);
        step(4'b1000, 8'h40, 1'b1, 8'h40, 1'b1, 4'b1000, 8'h40, 4'h0, 4'b0111);
        chk("full_cut_request", bus.request, 16'h2000);
        step(4'b1000, 8'h80, 1'b1, 8'h40, 1'b1, 4'b1000, 8'h40, 4'h0, 4'b0111);
        chk("split_request", bus.request, 16'h6000);

        // Load all 16 VOQs, then reset asynchronously between edges.
        for (int j = 0; j < 4; j++) begin
            logic [1:0] f;
            f = 2'(j);
            step(4'b1111, {f, f, f, f}, 1'b0, 8'h00, 1'b0, 4'h0, 8'h00, 4'h0, 4'h0);
        end
        chk("all_loaded_request", bus.request, 16'hFFFF);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_request", bus.request, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++)
            step(4'b0000, 8'h00, 1'b0, 8'h00, 1'b0, 4'h0, 8'h00, 4'h0, 4'h0);
        step(4'b0000, 8'h00, 1'b1, 8'h00, 1'b1, 4'b0000, 8'h00, 4'h0, 4'b1111);
        chk("post_reset_request", bus.request, 16'h0000);
        step(4'b0000, 8'h00, 1'b0, 8'h00, 1'b0, 4'h0, 8'h00, 4'h0, 4'h0);
        step(4'b0000, 8'h00, 1'b0, 8'h00, 1'b0, 4'h0, 8'h00, 4'h0, 4'h0);
        chk("scoreboard_drained", 16'(exp_q.size()), 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
